// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram: single-port word memory with a valid/ready request channel,
// a registered response channel with backpressure, per-byte write enables,
// a hardware zero-fill sweep (after reset and on demand) and out-of-range
// flagging.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   clear_req  start a zero-fill sweep (honoured only when READY)
//   req_valid  request present
//   req_ready  request accepted on this edge if req_valid is also high
//   req_write  1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables, bit i gates byte [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  response consumed on this edge if rsp_valid is also high
//   rsp_data   read data (0 on an error response)
//   rsp_err    address was out of range
//   busy       zero-fill sweep in progress
module mem_ctrl_ram #(
    parameter int unsigned A_SIZE     = 10,
    parameter int unsigned D_SIZE     = 32,
    parameter int unsigned DEPTH      = 128,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [A_SIZE-1:0]     req_addr,
    input  logic [D_SIZE-1:0]     req_wdata,
    input  logic [D_SIZE/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [D_SIZE-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned NUM_BYTES = D_SIZE / 8;
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2^A_SIZE still compares correctly.
    localparam logic [A_SIZE:0]  DEPTH_EXT = (A_SIZE + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [D_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [D_SIZE-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              wr_en;
    logic              rsp_load;
    logic              sweep_we;

    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
    // Only meaningful when in_range; the upper address bits are then zero.
    assign idx      = req_addr[IDX_W-1:0];
    assign sweep_we = (state_q == StClear);

    // A held, unconsumed response blocks new requests so nothing is lost.
    // rst is included so the request channel is closed while reset is held.
    assign req_ready = rst && (state_q == StReady) && !clear_req
                       && !(rsp_valid_q && !rsp_ready);

    assign accept   = req_valid && req_ready;
    assign wr_en    = accept && req_write && in_range;
    assign rsp_load = accept && (!req_write || !in_range);

    // Sweep sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StReady;
        endcase
    end

    // Response register: a new load wins over consumption on the same edge.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (rsp_load) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = in_range ? mem[idx] : '0;
            rsp_err_d   = !in_range;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT_CLEAR ? StClear : StReady;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array has no reset; contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = sweep_we;

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// Self-checking bench for mem_ctrl_ram: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_mem_ctrl_ram;

    localparam int unsigned A  = 10;
    localparam int unsigned D  = 32;
    localparam int unsigned DP = 128;
    localparam bit          IC = 1'b1;
    localparam int unsigned NB = D / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear_req = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [A-1:0]  req_addr = '0;
    logic [D-1:0]  req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [D-1:0]  rsp_data;
    logic          rsp_err;
    logic          busy;

    mem_ctrl_ram #(
        .A_SIZE    (A),
        .D_SIZE    (D),
        .DEPTH     (DP),
        .INIT_CLEAR(IC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear_req(clear_req),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [D-1:0] m_mem [DP];
    int           m_sweep;     // sweep cycles still to run
    logic         m_rv;
    logic [D-1:0] m_data;
    logic         m_err;
    logic         last_acc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
    endtask

    // Applies one clock edge worth of behaviour to the model.
    task automatic model_edge(input logic acc);
        int a;
        if (m_rv && rsp_ready) m_rv = 1'b0;
        if (m_sweep != 0) begin
            m_sweep--;
        end else if (clear_req) begin
            m_sweep = DP;
            model_zero();
        end
        if (acc && req_valid) begin
            a = int'(req_addr);
            if (a >= DP) begin
                m_rv = 1'b1; m_data = '0; m_err = 1'b1;
            end else if (req_write) begin
                for (int b = 0; b < NB; b++)
                    if (req_be[b]) m_mem[a][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                m_rv = 1'b1; m_data = m_mem[a]; m_err = 1'b0;
            end
        end
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, then takes the edge.
    task automatic cycle();
        logic exp_ready;
        @(negedge clk);
        exp_ready = (m_sweep == 0) && !clear_req && !(m_rv && !rsp_ready);
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("busy", 64'(busy), 64'(m_sweep != 0));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        if (m_rv) begin
            check_eq("rsp_data", 64'(rsp_data), 64'(m_data));
            check_eq("rsp_err", 64'(rsp_err), 64'(m_err));
        end
        last_acc = exp_ready && req_valid;
        model_edge(exp_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        clear_req = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Presents a request until the model predicts acceptance, bounded.
    task automatic send(input logic w, input int addr, input logic [D-1:0] data,
                        input logic [NB-1:0] be);
        int waited = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = A'(addr);
        req_wdata = data;
        req_be    = be;
        last_acc  = 1'b0;
        while (!last_acc && waited < 300) begin
            cycle();
            waited++;
        end
        check_eq("send_accept", 64'(last_acc), 64'(1));
        req_valid = 1'b0;
    endtask

    // Asserts reset at the current time (may be mid-cycle) and releases it
    // just after the following rising edge.
    task automatic apply_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        clear_req = 1'b0;
        #1;
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_rsp_data", 64'(rsp_data), 64'(0));
        check_eq("rst_rsp_err", 64'(rsp_err), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(IC));
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        m_rv = 1'b0; m_data = '0; m_err = 1'b0;
        m_sweep = IC ? DP : 0;
        model_zero();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_ready_after_sweep(input string tag);
        int n = 0;
        req_valid = 1'b0;
        while (m_sweep != 0 && n < 1000) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(n), 64'(DP));
    endtask

    initial begin
        m_rv = 1'b0; m_data = '0; m_err = 1'b0; m_sweep = 0;
        last_acc = 1'b0;
        model_zero();
        #2;
        apply_reset();

        // Reset sweep: busy for exactly DEPTH cycles.
        wait_ready_after_sweep("init_sweep_len");
        rsp_ready = 1'b1;
        send(1'b0, 0, '0, '0);
        send(1'b0, 7, '0, '0);
        send(1'b0, DP - 1, '0, '0);
        idle(2);

        // Byte-enable merge.
        send(1'b1, 5, 32'hAABBCCDD, 4'hF);
        send(1'b1, 5, 32'h11223344, 4'b0101);
        send(1'b0, 5, '0, '0);
        #2;
        check_eq("be_merge_valid", 64'(rsp_valid), 64'(1));
        check_eq("be_merge_data", 64'(rsp_data), 64'(32'hAA22CC44));
        idle(1);
        send(1'b1, 6, 32'h5555AAAA, 4'b0000);
        send(1'b0, 6, '0, '0);
        idle(1);

        // Backpressure: ordering and hold.
        send(1'b1, 1, 32'h1111_0001, 4'hF);
        send(1'b1, 2, 32'h2222_0002, 4'hF);
        send(1'b1, 3, 32'h3333_0003, 4'hF);
        send(1'b0, 1, '0, '0);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = A'(2);
        for (int i = 0; i < 4; i++) cycle();
        #2;
        check_eq("bp_hold_data", 64'(rsp_data), 64'(32'h1111_0001));
        check_eq("bp_req_ready", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        send(1'b0, 2, '0, '0);
        send(1'b0, 3, '0, '0);
        idle(2);

        // Out of range, then full readback.
        send(1'b1, 200, 32'hDEAD_BEEF, 4'hF);
        #2;
        check_eq("oor_wr_err", 64'(rsp_err), 64'(1));
        send(1'b0, 200, '0, '0);
        #2;
        check_eq("oor_rd_err", 64'(rsp_err), 64'(1));
        check_eq("oor_rd_data", 64'(rsp_data), 64'(0));
        for (int i = 0; i < DP; i++) send(1'b0, i, '0, '0);
        idle(1);

        // On-demand clear issued together with a request.
        for (int i = 0; i < DP; i++) send(1'b1, i, $urandom | 32'h1, 4'hF);
        idle(1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = A'(9);
        clear_req = 1'b1;
        cycle();
        check_eq("clr_not_acc", 64'(last_acc), 64'(0));
        clear_req = 1'b0;
        req_valid = 1'b0;
        wait_ready_after_sweep("clr_sweep_len");
        for (int i = 0; i < DP; i++) send(1'b0, i, '0, '0);
        idle(1);

        // Randomized traffic with occasional clears and backpressure.
        for (int n = 0; n < 3000; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = ($urandom_range(0, 5) == 0) ? A'($urandom_range(DP, 1023))
                                                    : A'($urandom_range(0, DP - 1));
            req_wdata = $urandom;
            req_be    = NB'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            clear_req = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rsp_ready = 1'b1;
        idle(DP + 2);

        // Reset during a sweep at counter 60.
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        idle(60);
        #3;
        apply_reset();
        wait_ready_after_sweep("rst_mid_sweep_len");

        // Reset while a response is held.
        send(1'b1, 4, 32'hCAFE_F00D, 4'hF);
        rsp_ready = 1'b0;
        send(1'b0, 4, '0, '0);
        idle(2);
        #2;
        apply_reset();
        rsp_ready = 1'b1;
        wait_ready_after_sweep("rst_held_sweep_len");
        send(1'b0, 4, '0, '0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
